// File: rtl/tf_pkg.sv
// tf_pkg: shared FFT twiddle constants and sequencer state encoding.
package tf_pkg;
    localparam int LOG2N = 8;
    localparam int N     = 1 << LOG2N;
    localparam int LANES = 4;
    localparam int NGRP  = N / (2 * LANES);
    localparam int SW    = 3;
    localparam int CW    = $clog2(NGRP);
    localparam int BW    = LOG2N - 1;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/tf_exp_lane.sv
// tf_exp_lane: twiddle exponent of one butterfly, e = (b & (span-1)) << s.
import tf_pkg::*;
module tf_exp_lane (
    input  logic [BW-1:0]    b,
    input  logic [SW-1:0]    s,
    output logic [LOG2N-1:0] e
);
    logic [LOG2N-1:0] mask;
    assign mask = (LOG2N'(N / 2) >> s) - LOG2N'(1);
    assign e    = ({1'b0, b} & mask) << s;
endmodule

// File: rtl/tf_exp_gen.sv
// tf_exp_gen: issues 4 twiddle exponents per cycle over all FFT stages, with
// TF_VLD/TF_LAST/DONE delayed one cycle to line up with the twiddle ROM output.
import tf_pkg::*;
module tf_exp_gen (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             START,
    input  logic             HOLD,
    output logic             BUSY,
    output logic [LOG2N-1:0] EXP0,
    output logic [LOG2N-1:0] EXP1,
    output logic [LOG2N-1:0] EXP2,
    output logic [LOG2N-1:0] EXP3,
    output logic             EXP_VLD,
    output logic [SW-1:0]    STAGE,
    output logic             TF_VLD,
    output logic             TF_LAST,
    output logic             DONE
);
    state_t           state, nxt;
    logic [SW-1:0]    s;
    logic [CW-1:0]    c;
    logic [LOG2N-1:0] e     [LANES];
    logic [LOG2N-1:0] exp_q [LANES];
    logic             issue, c_max, last_grp, last_q;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        tf_exp_lane u_lane (.b({c, 2'(k)}), .s(s), .e(e[k]));
    end

    assign c_max    = c == CW'(NGRP - 1);
    assign issue    = state == RUN && !HOLD;
    assign last_grp = c_max && s == SW'(LOG2N - 1);

    always_comb begin
        nxt = state;
        if (state == IDLE && START)
            nxt = RUN;
        else if (issue && last_grp)
            nxt = DRAIN;
        else if (state == DRAIN)
            nxt = IDLE;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state   <= IDLE;
            s       <= '0;
            c       <= '0;
            exp_q   <= '{default: '0};
            STAGE   <= '0;
            EXP_VLD <= 1'b0;
            last_q  <= 1'b0;
            TF_VLD  <= 1'b0;
            TF_LAST <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            state   <= nxt;
            EXP_VLD <= issue;
            TF_VLD  <= EXP_VLD;
            TF_LAST <= EXP_VLD && last_q;
            DONE    <= state == DRAIN;
            if (state == IDLE && START) begin
                s <= '0;
                c <= '0;
            end
            if (issue) begin
                exp_q  <= e;
                STAGE  <= s;
                last_q <= c_max;
                c      <= c_max ? '0 : c + CW'(1);
                s      <= c_max ? s + SW'(1) : s;
            end
        end
    end

    assign BUSY = state != IDLE;
    assign EXP0 = exp_q[0];
    assign EXP1 = exp_q[1];
    assign EXP2 = exp_q[2];
    assign EXP3 = exp_q[3];
endmodule

// File: tb/tb_tf_exp_gen.sv
// tb_tf_exp_gen: directed checks of the twiddle exponent sequencer for N=256.
module tb_tf_exp_gen;
    logic       CLK = 0, RSTn = 0, START = 0, HOLD = 0;
    logic       BUSY, EXP_VLD, TF_VLD, TF_LAST, DONE;
    logic [7:0] EXP0, EXP1, EXP2, EXP3;
    logic [2:0] STAGE;
    int checks = 0, errors = 0;

    tf_exp_gen dut (
        .CLK(CLK), .RSTn(RSTn), .START(START), .HOLD(HOLD), .BUSY(BUSY),
        .EXP0(EXP0), .EXP1(EXP1), .EXP2(EXP2), .EXP3(EXP3), .EXP_VLD(EXP_VLD),
        .STAGE(STAGE), .TF_VLD(TF_VLD), .TF_LAST(TF_LAST), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [63:0] all_out();
        return {24'd0, BUSY, EXP0, EXP1, EXP2, EXP3, EXP_VLD, STAGE, TF_VLD, TF_LAST, DONE};
    endfunction

    function automatic logic [7:0] emod(int g, int k);
        int b    = 4 * (g % 32) + k;
        int span = 128 >> (g / 32);
        return 8'((b % span) << (g / 32));
    endfunction

    // One full transform; START presented in cycle 0, cycle n observed after the n-th edge.
    task automatic run(input bit hold_en, input bit start_mid, input string tn);
        int g = 0, nv = 0, h = hold_en ? 5 : 0;
        bit vld_prev = 0, last_prev = 0, ev, has_sp;
        logic [7:0] ob [4];
        int sp [4];
        START = 1;
        for (int cyc = 1; cyc <= 265; cyc++) begin
            tick;
            START = start_mid && cyc == 100;
            HOLD  = hold_en && cyc >= 75 && cyc <= 79;
            ev = cyc >= 2 && cyc <= 257 + h && !(hold_en && cyc >= 76 && cyc <= 80);
            ob = '{EXP0, EXP1, EXP2, EXP3};
            nv += int'(EXP_VLD);
            chk({tn, " busy"}, BUSY, cyc <= 257 + h);
            chk({tn, " exp_vld"}, EXP_VLD, ev);
            chk({tn, " tf_vld"}, TF_VLD, vld_prev);
            chk({tn, " tf_last"}, TF_LAST, vld_prev && last_prev);
            chk({tn, " done"}, DONE, cyc == 258 + h);
            if (ev) begin
                chk({tn, " stage"}, STAGE, g / 32);
                for (int k = 0; k < 4; k++) chk({tn, " exp"}, ob[k], emod(g, k));
                has_sp = 1;
                case (g)
                    0:   sp = '{0, 1, 2, 3};
                    31:  sp = '{124, 125, 126, 127};
                    48:  sp = '{0, 2, 4, 6};
                    74:  sp = '{32, 36, 40, 44};
                    160: sp = '{0, 32, 64, 96};
                    192: sp = '{0, 64, 0, 64};
                    224: sp = '{0, 0, 0, 0};
                    default: has_sp = 0;
                endcase
                if (has_sp)
                    for (int k = 0; k < 4; k++) chk({tn, " spot"}, ob[k], sp[k]);
                last_prev = g % 32 == 31;
                g++;
            end else if (g > 0) begin
                for (int k = 0; k < 4; k++) chk({tn, " frozen"}, ob[k], emod(g - 1, k));
            end
            vld_prev = ev;
        end
        chk({tn, " groups"}, nv, 256);
        HOLD = 0;
    endtask

    initial begin
        #1;
        chk("reset", all_out(), 0);
        repeat (3) tick;
        RSTn = 1;
        repeat (10) begin
            tick;
            chk("idle", all_out(), 0);
        end
        run(0, 0, "full");
        run(1, 0, "hold");
        run(0, 1, "start_busy");
        START = 1;
        tick;
        START = 0;
        repeat (149) tick;
        chk("pre_abort busy", BUSY, 1);
        #2 RSTn = 0;
        #1 chk("abort async", all_out(), 0);
        repeat (3) begin
            tick;
            chk("abort held", all_out(), 0);
        end
        RSTn = 1;
        repeat (2) tick;
        chk("after abort", all_out(), 0);
        START = 1;
        tick;
        START = 0;
        chk("restart busy", BUSY, 1);
        tick;
        chk("restart vld", EXP_VLD, 1);
        chk("restart stage", STAGE, 0);
        chk("restart exp", {EXP0, EXP1, EXP2, EXP3}, {8'd0, 8'd1, 8'd2, 8'd3});
        tick;
        chk("restart exp2", {EXP0, EXP1, EXP2, EXP3}, {8'd4, 8'd5, 8'd6, 8'd7});
        chk("restart tf_vld", TF_VLD, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
